hash_io_shell_p: RTL and testbench
==================================

Name: hash_io_shell_p

Overview:
Parametrised host-side I/O shell for iterated 512-bit-block hash cores (BMW-256 class and successors). It deserialises W-bit message words into a BLK-bit block and tracks the chaining value across multiple blocks. It launches the core for each compression and for the finalization pass, then serialises the DIG-bit digest back out in W-bit words. The core sits outside this block on a start/done port pair, so one shell serves any core, IO width and digest length.

Parameters:
W, 16, IO word width; one of 8/16/32/64; must divide BLK and DIG.
BLK, 512, message block and chaining-value width in bits.
DIG, 256, digest bits output on fetch; multiple of W, <= BLK; taken from core_res[BLK-1 -: DIG].
IV0, BLK-bit constant (default BMW-256 IV 0x7c7d7e7f...40414243), chaining value loaded on init.
FINAL_CV, BLK-bit constant (default 0xaaaaaaaf...aaaaaaa0), chaining value used for the finalization pass.
BYTE_SWAP, 1, 1 = reverse byte order within each W-bit word on input and output; ignored when W=8.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
init  in  1  level; in IDLE, reload chaining value with IV0
load  in  1  level; word-valid strobe for message words
fetch  in  1  level; request for finalization, then digest words
idata  in  W  message word
ack  out  1  registered; word accepted (LOAD) or odata valid (OUT)
odata  out  W  registered digest word
busy  out  1  high in HASH, FIN or OUT, or while core_start is high
nblk  out  16  blocks compressed since last init; saturates at 0xFFFF
core_start  out  1  one-cycle launch pulse to the core
core_cv  out  BLK  chaining value to the core
core_msg  out  BLK  message block to the core
core_done  in  1  one-cycle completion pulse from the core
core_res  in  BLK  core result; valid while core_done is high

Behaviour:
- R = BLK/W words per block; D = DIG/W words per digest. Word counter is clog2(R)+1 bits wide.
- Reset values: ack=0, odata=0, busy=0, core_start=0, nblk=0, cv=0, msg=0, cnt=0, state=IDLE.
- Reset mid-operation aborts everything; core_done arriving after reset is ignored.
- FSM states: IDLE, LOAD, HASH, FIN, OUT.
- IDLE priority: init > load > fetch.
  - init: cv<=IV0, nblk<=0, stay in IDLE.
  - load: go to LOAD; the current word is captured in the same cycle.
  - fetch: pulse core_start with core_cv=FINAL_CV and core_msg=cv; go to FIN.
- LOAD: each cycle with load=1, msg[W*cnt +: W] <= swap(idata), cnt++, and ack=1 on the next cycle.
  - load=0 stalls with cnt held; ack=0.
  - On acceptance of word R-1: cnt<=0, core_start pulses the next cycle with core_cv=cv and core_msg=msg, then go to HASH.
- HASH: wait for core_done. On core_done: cv<=core_res, nblk++ (saturating), go to IDLE. The next load is accepted in the following cycle.
- FIN: wait for core_done. On core_done: dig<=core_res[BLK-1 -: DIG], go to OUT. cv is untouched, so a later fetch re-finalizes identically.
- OUT: each cycle with fetch=1, odata <= swap(dig word D-1-cnt) (most significant word first), ack=1 next cycle, cnt++.
  - fetch=0 stalls.
  - After word D-1: cnt<=0, go to IDLE.
- core_cv and core_msg hold stable from core_start until core_done.
- Inputs ignored outside their states: init outside IDLE; load in HASH, FIN or OUT; fetch in LOAD, HASH or FIN.
- core_done outside HASH/FIN is ignored.
- Partial blocks are not padded; the host supplies padded blocks.

Test Plan:
- Reset mid-LOAD (W=16, after 10 words) -> all outputs return to reset values; a following load restarts at word 0, with msg[15:0] equal to the new first word.
- Bench core (result=cv^msg, done 5 cycles after start). Sequence: init, then 32 words 16'h0100+i with BYTE_SWAP=1. Expected: core_msg[15:0]=16'h0001, core_start one cycle after the 32nd ack, cv=IV0^msg after done, nblk=1.
- Load dropped for 3 cycles mid-block -> cnt held, ack low for those cycles; the block completes with exactly 32 acks.
- Two blocks then fetch. Expected: FIN launches with core_cv=FINAL_CV and core_msg=cv. Then 16 fetch cycles give odata as words 31..16 of the result, each with ack=1 one cycle later; IDLE after the 16th.
- init, load and fetch all high in IDLE -> init alone acts (cv=IV0, nblk=0); load is taken on the next cycle.
- W=32, DIG=256 build -> 16 load words per block, 8 digest words out; W=8 build -> no byte swap, 64 words per block.

Source files
------------

// File: rtl/hash_io_shell_p.sv
`timescale 1ns/1ps
// Host-side I/O shell for iterated block-hash cores: deserialises message words,
// tracks the chaining value, sequences core launches and serialises the digest.
module hash_io_shell_p #(
    parameter int              W         = 16,
    parameter int              BLK       = 512,
    parameter int              DIG       = 256,
    parameter logic [BLK-1:0]  IV0       = 512'h7c7d7e7f_78797a7b_74757677_70717273_6c6d6e6f_68696a6b_64656667_60616263_5c5d5e5f_58595a5b_54555657_50515253_4c4d4e4f_48494a4b_44454647_40414243,
    parameter logic [BLK-1:0]  FINAL_CV  = 512'haaaaaaaf_aaaaaaae_aaaaaaad_aaaaaaac_aaaaaaab_aaaaaaaa_aaaaaaa9_aaaaaaa8_aaaaaaa7_aaaaaaa6_aaaaaaa5_aaaaaaa4_aaaaaaa3_aaaaaaa2_aaaaaaa1_aaaaaaa0,
    parameter bit              BYTE_SWAP = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init,
    input  logic           load,
    input  logic           fetch,
    input  logic [W-1:0]   idata,
    output logic           ack,
    output logic [W-1:0]   odata,
    output logic           busy,
    output logic [15:0]    nblk,
    output logic           core_start,
    output logic [BLK-1:0] core_cv,
    output logic [BLK-1:0] core_msg,
    input  logic           core_done,
    input  logic [BLK-1:0] core_res
);

    localparam int R  = BLK / W;
    localparam int D  = DIG / W;
    localparam int CW = $clog2(R) + 1;
    localparam logic [CW-1:0] R_LAST = CW'(R - 1);
    localparam logic [CW-1:0] D_LAST = CW'(D - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HASH, FIN, OUT} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [BLK-1:0] cv, msg;
    logic [DIG-1:0] dig;
    logic           hash_launch;
    logic           do_init, do_cap, do_fin, do_out, hash_done, fin_done;

    function automatic logic [W-1:0] swap(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x;
        if (BYTE_SWAP && W > 8) begin
            for (int i = 0; i < W / 8; i++) begin
                y[8*i +: 8] = x[W-8-8*i +: 8];
            end
        end
        return y;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_init   = 1'b0;
        do_cap    = 1'b0;
        do_fin    = 1'b0;
        do_out    = 1'b0;
        hash_done = 1'b0;
        fin_done  = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    do_init = 1'b1;
                end else if (load) begin
                    do_cap   = 1'b1;
                    state_nx = (cnt == R_LAST) ? HASH : LOAD;
                end else if (fetch) begin
                    do_fin   = 1'b1;
                    state_nx = FIN;
                end
            end
            LOAD: begin
                if (load) begin
                    do_cap = 1'b1;
                    if (cnt == R_LAST) state_nx = HASH;
                end
            end
            HASH: begin
                if (core_done) begin
                    hash_done = 1'b1;
                    state_nx  = IDLE;
                end
            end
            FIN: begin
                if (core_done) begin
                    fin_done = 1'b1;
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (fetch) begin
                    do_out = 1'b1;
                    if (cnt == D_LAST) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The hash launch is delayed one cycle so the last word is already in msg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack         <= 1'b0;
            odata       <= '0;
            core_start  <= 1'b0;
            hash_launch <= 1'b0;
            nblk        <= '0;
            cv          <= '0;
            msg         <= '0;
            cnt         <= '0;
        end else begin
            ack         <= do_cap | do_out;
            hash_launch <= do_cap && (cnt == R_LAST);
            core_start  <= hash_launch | do_fin;
            if (do_init) begin
                cv   <= IV0;
                nblk <= '0;
            end
            if (do_cap) begin
                msg[W*int'(cnt) +: W] <= swap(idata);
                cnt <= (cnt == R_LAST) ? '0 : cnt + 1'b1;
            end
            if (do_out) begin
                odata <= swap(dig[W*(D-1-int'(cnt)) +: W]);
                cnt   <= (cnt == D_LAST) ? '0 : cnt + 1'b1;
            end
            if (hash_done) begin
                cv <= core_res;
                if (nblk != 16'hFFFF) nblk <= nblk + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fin_done) dig <= core_res[BLK-1 -: DIG];
    end

    // Finalization compresses the chaining value as the message under FINAL_CV.
    assign core_cv  = (state == FIN) ? FINAL_CV : cv;
    assign core_msg = (state == FIN) ? cv : msg;
    assign busy     = (state == HASH) || (state == FIN) || (state == OUT) || core_start;

endmodule

// File: tb/tb_hash_io_shell_p.sv
`timescale 1ns/1ps
// Bench for hash_io_shell_p: W=16, W=32 and W=8 shells, each driving a simple
// xor core (result = cv ^ msg, done five cycles after start).
module tb_hash_io_shell_p;

    localparam logic [511:0] IV0 = 512'h7c7d7e7f_78797a7b_74757677_70717273_6c6d6e6f_68696a6b_64656667_60616263_5c5d5e5f_58595a5b_54555657_50515253_4c4d4e4f_48494a4b_44454647_40414243;
    localparam logic [511:0] FCV = 512'haaaaaaaf_aaaaaaae_aaaaaaad_aaaaaaac_aaaaaaab_aaaaaaaa_aaaaaaa9_aaaaaaa8_aaaaaaa7_aaaaaaa6_aaaaaaa5_aaaaaaa4_aaaaaaa3_aaaaaaa2_aaaaaaa1_aaaaaaa0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_cv;
    logic [15:0]  exp_nblk;

    logic a_init = 0, a_load = 0, a_fetch = 0, a_ack, a_busy, a_core_start, a_core_done;
    logic [15:0]  a_idata = '0, a_odata, a_nblk;
    logic [511:0] a_core_cv, a_core_msg, a_core_res;
    logic [4:0]   a_sr = '0;

    logic b_init = 0, b_load = 0, b_fetch = 0, b_ack, b_busy, b_core_start, b_core_done;
    logic [31:0]  b_idata = '0, b_odata;
    logic [15:0]  b_nblk;
    logic [511:0] b_core_cv, b_core_msg, b_core_res;
    logic [4:0]   b_sr = '0;

    logic c_init = 0, c_load = 0, c_fetch = 0, c_ack, c_busy, c_core_start, c_core_done;
    logic [7:0]   c_idata = '0, c_odata;
    logic [15:0]  c_nblk;
    logic [511:0] c_core_cv, c_core_msg, c_core_res;
    logic [4:0]   c_sr = '0;

    hash_io_shell_p #(.W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .init(a_init), .load(a_load), .fetch(a_fetch),
        .idata(a_idata), .ack(a_ack), .odata(a_odata), .busy(a_busy), .nblk(a_nblk),
        .core_start(a_core_start), .core_cv(a_core_cv), .core_msg(a_core_msg),
        .core_done(a_core_done), .core_res(a_core_res));

    hash_io_shell_p #(.W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .init(b_init), .load(b_load), .fetch(b_fetch),
        .idata(b_idata), .ack(b_ack), .odata(b_odata), .busy(b_busy), .nblk(b_nblk),
        .core_start(b_core_start), .core_cv(b_core_cv), .core_msg(b_core_msg),
        .core_done(b_core_done), .core_res(b_core_res));

    hash_io_shell_p #(.W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .init(c_init), .load(c_load), .fetch(c_fetch),
        .idata(c_idata), .ack(c_ack), .odata(c_odata), .busy(c_busy), .nblk(c_nblk),
        .core_start(c_core_start), .core_cv(c_core_cv), .core_msg(c_core_msg),
        .core_done(c_core_done), .core_res(c_core_res));

    // Bench cores: xor result, done pulse five cycles after the start pulse.
    always_ff @(posedge clk) begin
        a_sr <= {a_sr[3:0], a_core_start};
        b_sr <= {b_sr[3:0], b_core_start};
        c_sr <= {c_sr[3:0], c_core_start};
    end
    assign a_core_done = a_sr[4];
    assign b_core_done = b_sr[4];
    assign c_core_done = c_sr[4];
    assign a_core_res  = a_core_cv ^ a_core_msg;
    assign b_core_res  = b_core_cv ^ b_core_msg;
    assign c_core_res  = c_core_cv ^ c_core_msg;

    function automatic logic [15:0] sw16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [31:0] sw32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [511:0] pack16(input logic [15:0] w[32]);
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m = m | (512'(sw16(w[i])) << (16 * i));
        return m;
    endfunction

    task automatic do_reset();
        a_init = 0; a_load = 0; a_fetch = 0;
        b_init = 0; b_load = 0; b_fetch = 0;
        c_init = 0; c_load = 0; c_fetch = 0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_block_a(input logic [15:0] w[32], input int gap_at, input int gap_len,
                               output int n_ack, output int n_gap_ack, output int start_lag,
                               output logic [511:0] msg_s, output logic [511:0] cv_s, output bit tmo);
        int  k, cyc, last_ack, gap_left;
        bit  prev_gap, started;
        k = 0; cyc = 0; last_ack = -100; gap_left = gap_len; prev_gap = 0;
        n_ack = 0; n_gap_ack = 0; started = 0; start_lag = -1; msg_s = '0; cv_s = '0;
        while (k < 32) begin
            @(negedge clk); cyc++;
            if (a_ack) begin
                n_ack++; last_ack = cyc;
                if (prev_gap) n_gap_ack++;
            end
            if (k == gap_at && gap_left > 0) begin
                a_load = 0; gap_left--; prev_gap = 1;
            end else begin
                a_load = 1; a_idata = w[k]; k++; prev_gap = 0;
            end
        end
        for (int i = 0; i < 10 && !started; i++) begin
            @(negedge clk); cyc++;
            a_load = 0;
            if (a_ack) begin n_ack++; last_ack = cyc; end
            if (a_core_start) begin
                started = 1; start_lag = cyc - last_ack; msg_s = a_core_msg; cv_s = a_core_cv;
            end
        end
        tmo = !started;
        for (int i = 0; i < 20 && a_busy; i++) @(negedge clk);
        if (a_busy) tmo = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", a_ack); end
        checks++; if (a_odata !== 16'h0) begin errors++; $display("FAIL reset_odata: got %h want 0", a_odata); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        checks++; if (a_core_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", a_core_start); end
        checks++; if (a_nblk !== 16'h0) begin errors++; $display("FAIL reset_nblk: got %h want 0", a_nblk); end
        checks++; if (a_core_cv !== 512'h0) begin errors++; $display("FAIL reset_cv: got %h want 0", a_core_cv); end
        checks++; if (a_core_msg !== 512'h0) begin errors++; $display("FAIL reset_msg: got %h want 0", a_core_msg); end
    endtask

    task automatic test_single_block();
        logic [15:0]  w[32];
        logic [511:0] m, msg_s, cv_s;
        int n_ack, n_gap, lag;
        bit tmo;
        @(negedge clk); a_init = 1;
        @(negedge clk); a_init = 0;
        exp_cv = IV0; exp_nblk = 0;
        for (int i = 0; i < 32; i++) w[i] = 16'h0100 + 16'(i);
        m = pack16(w);
        run_block_a(w, -1, 0, n_ack, n_gap, lag, msg_s, cv_s, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL blk1_timeout: launch/done not seen in budget"); end
        checks++; if (n_ack != 32) begin errors++; $display("FAIL blk1_acks: got %0d want 32", n_ack); end
        checks++; if (msg_s[15:0] !== 16'h0001) begin errors++; $display("FAIL blk1_word0: got %h want 0001", msg_s[15:0]); end
        checks++; if (msg_s !== m) begin errors++; $display("FAIL blk1_msg: got %h want %h", msg_s, m); end
        checks++; if (cv_s !== exp_cv) begin errors++; $display("FAIL blk1_cv_in: got %h want %h", cv_s, exp_cv); end
        checks++; if (lag != 1) begin errors++; $display("FAIL blk1_start_lag: got %0d want 1", lag); end
        exp_cv = exp_cv ^ m; exp_nblk++;
        checks++; if (a_core_cv !== exp_cv) begin errors++; $display("FAIL blk1_cv_out: got %h want %h", a_core_cv, exp_cv); end
        checks++; if (a_nblk !== exp_nblk) begin errors++; $display("FAIL blk1_nblk: got %0d want %0d", a_nblk, exp_nblk); end
    endtask

    task automatic test_load_stall();
        logic [15:0]  w[32];
        logic [511:0] m, msg_s, cv_s;
        int n_ack, n_gap, lag;
        bit tmo;
        for (int i = 0; i < 32; i++) w[i] = 16'($urandom);
        m = pack16(w);
        run_block_a(w, 10, 3, n_ack, n_gap, lag, msg_s, cv_s, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL stall_timeout: launch/done not seen in budget"); end
        checks++; if (n_ack != 32) begin errors++; $display("FAIL stall_acks: got %0d want 32", n_ack); end
        checks++; if (n_gap != 0) begin errors++; $display("FAIL stall_gap_ack: got %0d acks during gap want 0", n_gap); end
        checks++; if (msg_s !== m) begin errors++; $display("FAIL stall_msg: got %h want %h", msg_s, m); end
        checks++; if (cv_s !== exp_cv) begin errors++; $display("FAIL stall_cv_in: got %h want %h", cv_s, exp_cv); end
        exp_cv = exp_cv ^ m; exp_nblk++;
        checks++; if (a_core_cv !== exp_cv) begin errors++; $display("FAIL stall_cv_out: got %h want %h", a_core_cv, exp_cv); end
        checks++; if (a_nblk !== exp_nblk) begin errors++; $display("FAIL stall_nblk: got %0d want %0d", a_nblk, exp_nblk); end
    endtask

    task automatic test_fetch();
        logic [511:0] res;
        logic [15:0]  want;
        int  n, stall_left, n_stall_ack;
        bit  fin_seen, prev_stall;
        res = FCV ^ exp_cv;
        @(negedge clk); a_fetch = 1;
        fin_seen = 0;
        for (int i = 0; i < 5 && !fin_seen; i++) begin
            @(negedge clk);
            if (a_core_start) fin_seen = 1;
        end
        checks++; if (!fin_seen) begin errors++; $display("FAIL fin_launch: core_start not seen"); end
        checks++; if (a_core_cv !== FCV) begin errors++; $display("FAIL fin_cv: got %h want %h", a_core_cv, FCV); end
        checks++; if (a_core_msg !== exp_cv) begin errors++; $display("FAIL fin_msg: got %h want %h", a_core_msg, exp_cv); end
        n = 0; stall_left = 2; prev_stall = 0; n_stall_ack = 0;
        for (int i = 0; i < 60 && n < 16; i++) begin
            @(negedge clk);
            if (a_ack) begin
                if (prev_stall) n_stall_ack++;
                want = sw16(res[16*(31-n) +: 16]);
                checks++; if (a_odata !== want) begin errors++; $display("FAIL dig_word%0d: got %h want %h", n, a_odata, want); end
                n++;
            end
            if (n == 5 && stall_left > 0) begin
                a_fetch = 0; stall_left--; prev_stall = 1;
            end else begin
                a_fetch = (n < 16); prev_stall = 0;
            end
        end
        a_fetch = 0;
        checks++; if (n != 16) begin errors++; $display("FAIL dig_count: got %0d want 16", n); end
        checks++; if (n_stall_ack != 0) begin errors++; $display("FAIL dig_stall_ack: got %0d want 0", n_stall_ack); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL dig_idle: busy %b want 0", a_busy); end
        checks++; if (a_core_cv !== exp_cv) begin errors++; $display("FAIL dig_cv_kept: got %h want %h", a_core_cv, exp_cv); end
        checks++; if (a_nblk !== exp_nblk) begin errors++; $display("FAIL dig_nblk: got %0d want %0d", a_nblk, exp_nblk); end
    endtask

    task automatic test_priority();
        @(negedge clk); a_init = 1; a_load = 1; a_fetch = 1; a_idata = 16'h1234;
        @(negedge clk);
        checks++; if (a_core_cv !== IV0) begin errors++; $display("FAIL prio_cv: got %h want %h", a_core_cv, IV0); end
        checks++; if (a_nblk !== 16'h0) begin errors++; $display("FAIL prio_nblk: got %0d want 0", a_nblk); end
        checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL prio_ack: got %b want 0", a_ack); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b want 0", a_busy); end
        a_init = 0; a_fetch = 0;
        @(negedge clk);
        checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL prio_load_next: ack %b want 1", a_ack); end
        checks++; if (a_core_msg[15:0] !== 16'h3412) begin errors++; $display("FAIL prio_word0: got %h want 3412", a_core_msg[15:0]); end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] nw;
        for (int i = 0; i < 9; i++) begin
            a_load = 1; a_idata = 16'($urandom);
            @(negedge clk);
        end
        a_load = 0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", a_ack); end
        checks++; if (a_odata !== 16'h0) begin errors++; $display("FAIL rstmid_odata: got %h want 0", a_odata); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
        checks++; if (a_core_cv !== 512'h0) begin errors++; $display("FAIL rstmid_cv: got %h want 0", a_core_cv); end
        checks++; if (a_core_msg !== 512'h0) begin errors++; $display("FAIL rstmid_msg: got %h want 0", a_core_msg); end
        rst_n = 1'b1;
        nw = 16'($urandom);
        @(negedge clk); a_load = 1; a_idata = nw;
        @(negedge clk); a_load = 0;
        checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL rstmid_reload_ack: got %b want 1", a_ack); end
        checks++; if (a_core_msg[15:0] !== sw16(nw)) begin errors++; $display("FAIL rstmid_word0: got %h want %h", a_core_msg[15:0], sw16(nw)); end
        checks++; if (a_core_msg[511:16] !== '0) begin errors++; $display("FAIL rstmid_upper: got %h want 0", a_core_msg[511:16]); end
    endtask

    task automatic test_w32();
        logic [31:0]  w[16];
        logic [511:0] m, cv, res, msg_s;
        logic [31:0]  want;
        int  na, n;
        bit  started;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            m = m | (512'(sw32(w[i])) << (32 * i));
        end
        @(negedge clk); b_init = 1;
        @(negedge clk); b_init = 0;
        na = 0; started = 0; msg_s = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (b_ack) na++;
            b_load = 1; b_idata = w[i];
        end
        for (int i = 0; i < 10 && !started; i++) begin
            @(negedge clk); b_load = 0;
            if (b_ack) na++;
            if (b_core_start) begin started = 1; msg_s = b_core_msg; end
        end
        checks++; if (na != 16) begin errors++; $display("FAIL w32_acks: got %0d want 16", na); end
        checks++; if (!started || msg_s !== m) begin errors++; $display("FAIL w32_msg: got %h want %h", msg_s, m); end
        for (int i = 0; i < 20 && b_busy; i++) @(negedge clk);
        cv = IV0 ^ m;
        checks++; if (b_core_cv !== cv) begin errors++; $display("FAIL w32_cv: got %h want %h", b_core_cv, cv); end
        res = FCV ^ cv;
        @(negedge clk); b_fetch = 1;
        n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            @(negedge clk);
            if (b_ack) begin
                want = sw32(res[32*(15-n) +: 32]);
                checks++; if (b_odata !== want) begin errors++; $display("FAIL w32_dig%0d: got %h want %h", n, b_odata, want); end
                n++;
            end
            if (n == 8) b_fetch = 0;
        end
        b_fetch = 0;
        checks++; if (n != 8) begin errors++; $display("FAIL w32_dig_count: got %0d want 8", n); end
    endtask

    task automatic test_w8();
        logic [7:0]   w[64];
        logic [511:0] m, cv, res, msg_s;
        logic [7:0]   want;
        int  na, n;
        bit  started;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            w[i] = 8'($urandom);
            m = m | (512'(w[i]) << (8 * i));
        end
        @(negedge clk); c_init = 1;
        @(negedge clk); c_init = 0;
        na = 0; started = 0; msg_s = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (c_ack) na++;
            c_load = 1; c_idata = w[i];
        end
        for (int i = 0; i < 10 && !started; i++) begin
            @(negedge clk); c_load = 0;
            if (c_ack) na++;
            if (c_core_start) begin started = 1; msg_s = c_core_msg; end
        end
        checks++; if (na != 64) begin errors++; $display("FAIL w8_acks: got %0d want 64", na); end
        checks++; if (!started || msg_s !== m) begin errors++; $display("FAIL w8_msg: got %h want %h", msg_s, m); end
        for (int i = 0; i < 20 && c_busy; i++) @(negedge clk);
        cv = IV0 ^ m;
        checks++; if (c_core_cv !== cv) begin errors++; $display("FAIL w8_cv: got %h want %h", c_core_cv, cv); end
        res = FCV ^ cv;
        @(negedge clk); c_fetch = 1;
        n = 0;
        for (int i = 0; i < 80 && n < 32; i++) begin
            @(negedge clk);
            if (c_ack) begin
                want = res[8*(63-n) +: 8];
                checks++; if (c_odata !== want) begin errors++; $display("FAIL w8_dig%0d: got %h want %h", n, c_odata, want); end
                n++;
            end
            if (n == 32) c_fetch = 0;
        end
        c_fetch = 0;
        checks++; if (n != 32) begin errors++; $display("FAIL w8_dig_count: got %0d want 32", n); end
    endtask

    initial begin
        exp_cv = '0;
        exp_nblk = '0;
        test_reset();
        test_single_block();
        test_load_stall();
        test_fetch();
        test_fetch();
        test_priority();
        test_reset_mid_load();
        do_reset();
        test_w32();
        test_w8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
